gate_sweep_checker: RTL and testbench
=====================================

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles each input vector is held before the response is sampled; legal range 1..15.
REQ-002 SHALL have parameter EXPECT_FN, default 0: the expected 2-input function, coded 0=XOR, 1=XNOR, 2=AND, 3=OR, 4=NAND, 5=NOR.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  starts a sweep when sampled high in IDLE or DONE.
REQ-006 SHALL have port dut_s  input  1  response of the 2-input gate under test.
REQ-007 SHALL have port a  output  1  registered gate input; equals vec[1].
REQ-008 SHALL have port b  output  1  registered gate input; equals vec[0].
REQ-009 SHALL have port vec  output  2  index of the vector currently applied.
REQ-010 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-011 SHALL have port done  output  1  high from sweep completion until the next start or reset.
REQ-012 SHALL have port pass  output  1  high only when done=1 and err_cnt=0.
REQ-013 SHALL have port err_cnt  output  3  number of mismatching vectors in the current or last sweep, range 0..4.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, DONE.
REQ-015 SHALL, on start=1 in IDLE or DONE, enter SETTLE on the same edge with vec=0, a=0, b=0, err_cnt=0, done=0, pass=0, busy=1, and settle counter=0.
REQ-016 SHALL ignore start while in SETTLE.
REQ-017 SHALL, in SETTLE, increment the settle counter each cycle; the edge on which the counter reaches SETTLE_CYCLES-1 is the sample edge for the current vec.
REQ-018 SHALL, on the sample edge, compare dut_s with EXPECT_FN(vec[1],vec[0]) and increment err_cnt on mismatch.
REQ-019 SHALL, on a sample edge with vec<3, increment vec, update a and b on that same edge, and clear the settle counter.
REQ-020 SHALL, on the sample edge with vec=3, enter DONE with busy=0, done=1, pass=(final err_cnt==0), and vec, a, b held at 3, 1, 1.
REQ-021 SHALL sample the vector-i response at edge SETTLE_CYCLES*(i+1) after the start edge and assert done after edge 4*SETTLE_CYCLES (edge 8 for the default).
REQ-022 SHALL saturate err_cnt at 4, which is reachable only as the 4-of-4 mismatch case.
REQ-023 SHALL treat an EXPECT_FN value outside 0..5 as XOR.
REQ-024 SHALL leave DONE only on start or rst; IDLE is re-entered only through reset.

Reset
REQ-025 SHALL, while rst=1 and independent of clk, force state=IDLE, vec=0, a=0, b=0, settle counter=0, err_cnt=0, busy=0, done=0, pass=0, and first_fail=0 when present.
REQ-026 SHALL abort a sweep that is in progress when rst is asserted, with no partial result retained, and accept start on the first edge after rst is released.

Configuration
REQ-027 SHALL recognise macro GATE_SWEEP_FAIL_CAPTURE_EN.
REQ-028 SHALL, when GATE_SWEEP_FAIL_CAPTURE_EN is defined, add port first_fail  output  3  {valid, vec[1:0]} of the first mismatching vector in a sweep, cleared on start and written only while valid=0.
REQ-029 SHALL, when GATE_SWEEP_FAIL_CAPTURE_EN is undefined, omit the first_fail port and its register, with all other behaviour identical.

Verification
REQ-030 SHALL cover: default parameters, dut_s = a^b, start pulse -> a/b step 00,01,10,11 every 2 cycles; done=1 after edge 8; err_cnt=0; pass=1.
REQ-031 SHALL cover: dut_s tied 0, EXPECT_FN=0 -> err_cnt=2, pass=0; with the macro, first_fail=3'b101.
REQ-032 SHALL cover: dut_s = ~(a^b), EXPECT_FN=0 -> err_cnt=4, pass=0; then EXPECT_FN=1 with the same DUT -> err_cnt=0, pass=1.
REQ-033 SHALL cover: rst pulsed while vec=2 -> all outputs 0 immediately; a new start completes normally with a correct DUT.
REQ-034 SHALL cover: start held high for the whole sweep -> one sweep with unchanged timing; in DONE a new sweep starts on the next edge and done drops.
REQ-035 SHALL cover: SETTLE_CYCLES=1, EXPECT_FN=5, dut_s = ~(a|b) -> done after edge 4, err_cnt=0, pass=1.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: applies vectors 00,01,10,11 to a 2-input gate and counts responses that differ from EXPECT_FN; optional first-fail capture under GATE_SWEEP_FAIL_CAPTURE_EN
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int EXPECT_FN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_s,
    output logic       a,
    output logic       b,
    output logic [1:0] vec,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    ,
    output logic [2:0] first_fail
`endif
);
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
    state_t state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] err_q, err_d;
    logic expect_s, sample, mismatch;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    logic [2:0] ff_q, ff_d;
    assign first_fail = ff_q;
`endif
    assign a = vec_q[1];
    assign b = vec_q[0];
    assign vec = vec_q;
    assign err_cnt = err_q;
    assign busy = state_q == SETTLE;
    assign done = state_q == DONE;
    assign pass = done && err_q == 3'd0;
    // expected gate response for the vector on the pins; unknown codes fall back to XOR
    always_comb begin
        expect_s = EXPECT_FN == 1 ? ~(vec_q[1] ^ vec_q[0]) :
                   EXPECT_FN == 2 ? vec_q[1] & vec_q[0] :
                   EXPECT_FN == 3 ? vec_q[1] | vec_q[0] :
                   EXPECT_FN == 4 ? ~(vec_q[1] & vec_q[0]) :
                   EXPECT_FN == 5 ? ~(vec_q[1] | vec_q[0]) :
                   vec_q[1] ^ vec_q[0];
    end
    // sweep sequencing: settle, sample, advance vector or finish
    always_comb begin
        state_d = state_q;
        vec_d = vec_q;
        cnt_d = cnt_q;
        err_d = err_q;
        sample = state_q == SETTLE && cnt_q == 4'(SETTLE_CYCLES - 1);
        mismatch = sample && dut_s != expect_s;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        ff_d = ff_q;
`endif
        if (state_q != SETTLE && start) begin
            state_d = SETTLE;
            vec_d = 2'd0;
            cnt_d = 4'd0;
            err_d = 3'd0;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
            ff_d = 3'd0;
`endif
        end else if (state_q == SETTLE) begin
            cnt_d = sample ? 4'd0 : cnt_q + 4'd1;
            err_d = mismatch && err_q != 3'd4 ? err_q + 3'd1 : err_q;
            vec_d = sample && vec_q != 2'd3 ? vec_q + 2'd1 : vec_q;
            state_d = sample && vec_q == 2'd3 ? DONE : SETTLE;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
            ff_d = mismatch && !ff_q[2] ? {1'b1, vec_q} : ff_q;
`endif
        end
    end
    // state registers, cleared asynchronously so a sweep in progress is discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q <= 2'd0;
            cnt_q <= 4'd0;
            err_q <= 3'd0;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
            ff_q <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            vec_q <= vec_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
            ff_q <= ff_d;
`endif
        end
    end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed bench for gate_sweep_checker across three parameter sets
module tb_gate_sweep_checker;
    logic clk = 1'b0, rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    int mode = 0;
    int checks = 0, errors = 0;
    logic a0, b0, busy0, done0, pass0, s0;
    logic a1, b1, busy1, done1, pass1, s1;
    logic a2, b2, busy2, done2, pass2, s2;
    logic [1:0] vec0, vec1, vec2;
    logic [2:0] err0, err1, err2;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
    logic [2:0] ff0, ff1, ff2;
`endif
    always #5 clk = ~clk;
    assign s0 = mode == 0 ? a0 ^ b0 : mode == 1 ? 1'b0 : ~(a0 ^ b0);
    assign s1 = ~(a1 ^ b1);
    assign s2 = ~(a2 | b2);
    gate_sweep_checker u0 (.clk(clk), .rst(rst), .start(start0), .dut_s(s0), .a(a0), .b(b0), .vec(vec0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        , .first_fail(ff0)
`endif
    );
    gate_sweep_checker #(.SETTLE_CYCLES(2), .EXPECT_FN(1)) u1 (.clk(clk), .rst(rst), .start(start1), .dut_s(s1),
        .a(a1), .b(b1), .vec(vec1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        , .first_fail(ff1)
`endif
    );
    gate_sweep_checker #(.SETTLE_CYCLES(1), .EXPECT_FN(5)) u2 (.clk(clk), .rst(rst), .start(start2), .dut_s(s2),
        .a(a2), .b(b2), .vec(vec2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        , .first_fail(ff2)
`endif
    );
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        #2;
        chk("rst_vec", vec0, 0);
        chk("rst_ab", {a0, b0}, 0);
        chk("rst_flags", {busy0, done0, pass0}, 0);
        chk("rst_err", err0, 0);
        tick;
        rst = 1'b0;
        tick;
        chk("idle_busy", busy0, 0);
        // correct XOR gate, vectors step every two cycles
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        chk("go_busy", busy0, 1);
        chk("go_vec", vec0, 0);
        for (int e = 1; e <= 8; e++) begin
            tick;
            chk("sweep_ab", {a0, b0}, e < 2 ? 0 : e >= 6 ? 3 : e / 2);
            chk("sweep_done", done0, e == 8 ? 1 : 0);
        end
        chk("xor_err", err0, 0);
        chk("xor_pass", pass0, 1);
        chk("xor_busy", busy0, 0);
        // stuck-at-0 output against XOR
        mode = 1;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        chk("stuck_clr_done", done0, 0);
        repeat (8) tick;
        chk("stuck_done", done0, 1);
        chk("stuck_err", err0, 2);
        chk("stuck_pass", pass0, 0);
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        chk("stuck_ff", ff0, 5);
`endif
        // XNOR gate against XOR and XNOR expectations
        mode = 2;
        start0 = 1'b1;
        start1 = 1'b1;
        tick;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (8) tick;
        chk("xnor_err0", err0, 4);
        chk("xnor_pass0", pass0, 0);
        chk("xnor_err1", err1, 0);
        chk("xnor_pass1", pass1, 1);
        chk("xnor_done1", done1, 1);
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        chk("xnor_ff0", ff0, 4);
        chk("xnor_ff1", ff1, 0);
`endif
        // reset mid-sweep at vec=2
        mode = 0;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        repeat (4) tick;
        chk("pre_rst_vec", vec0, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_vec", vec0, 0);
        chk("mid_rst_ab", {a0, b0}, 0);
        chk("mid_rst_flags", {busy0, done0, pass0}, 0);
        chk("mid_rst_err", err0, 0);
        chk("mid_rst_u1", {done1, pass1}, 0);
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
        chk("mid_rst_ff", ff0, 0);
`endif
        #2;
        rst = 1'b0;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        chk("post_rst_busy", busy0, 1);
        chk("post_rst_vec", vec0, 0);
        repeat (8) tick;
        chk("post_rst_done", done0, 1);
        chk("post_rst_pass", pass0, 1);
        chk("post_rst_err", err0, 0);
        // start held high through the whole sweep
        start0 = 1'b1;
        tick;
        repeat (3) tick;
        chk("hold_vec3", vec0, 1);
        tick;
        chk("hold_vec4", vec0, 2);
        repeat (3) tick;
        chk("hold_e7", {done0, busy0, vec0}, 7);
        tick;
        chk("hold_done", done0, 1);
        chk("hold_pass", pass0, 1);
        tick;
        chk("hold_restart", {done0, busy0, vec0}, 4);
        start0 = 1'b0;
        // single-cycle settle with NOR expectation
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick;
            chk("nor_vec", vec2, e > 3 ? 3 : e);
            chk("nor_done", done2, e == 4 ? 1 : 0);
        end
        chk("nor_err", err2, 0);
        chk("nor_pass", pass2, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
